ps2_scancode_decoder: RTL

Sits directly downstream of the PS/2 receive FIFO. It pops raw scan-code bytes through the FIFO's ready/nextdata_n handshake and strips the E0 (extended) and F0 (break) prefixes. It emits one key event per complete make/break sequence and tracks the held key, shift and caps-lock state and a press counter. Events are handed to the consumer, typically the keycode-to-ASCII lookup and display logic, over a valid/ready handshake with backpressure.

---
 rtl/ps2_scancode_decoder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: pops raw bytes from the receive FIFO and strips the E0/F0 prefixes.
// It emits one registered key event per make/break sequence, with held-key, shift and caps tracking.
`timescale 1ns/1ps
module ps2_scancode_decoder #(
    parameter logic [7:0] LSHIFT_CODE = 8'h12,
    parameter logic [7:0] RSHIFT_CODE = 8'h59,
    parameter logic [7:0] CAPS_CODE   = 8'h58
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] ps2_data,
    input  logic       ps2_ready,
    output logic       nextdata_n,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_make,
    output logic       ev_repeat,
    output logic       ev_shift,
    output logic       ev_caps,
    output logic [7:0] press_count,
    output logic       proto_err
);

    typedef enum logic [1:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       held_valid;
    logic [7:0] held_code;
    logic       held_ext;
    logic       lshift;
    logic       rshift;
    logic       caps;

    logic       pop;
    logic       is_e0;
    logic       is_f0;
    logic       emit;
    logic       emit_ext;
    logic       emit_make;
    logic       err_set;
    logic       held_match;
    logic       is_repeat;
    logic       held_valid_next;
    logic       lshift_next;
    logic       rshift_next;
    logic       caps_next;

    // A byte is only taken when the event slot is free or being drained this edge.
    assign pop        = ps2_ready & (~ev_valid | ev_ready);
    assign nextdata_n = ~(pop & clrn);
    assign is_e0      = (ps2_data == 8'hE0);
    assign is_f0      = (ps2_data == 8'hF0);

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_make  = 1'b0;
        err_set    = 1'b0;
        if (pop) begin
            case (state)
                IDLE: begin
                    if (is_e0) begin
                        state_next = GOT_E0;
                    end else if (is_f0) begin
                        state_next = GOT_F0;
                    end else if (ps2_data != 8'hAA && ps2_data != 8'h00 && ps2_data != 8'hFF) begin
                        emit      = 1'b1;
                        emit_make = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (is_f0) begin
                        state_next = GOT_E0F0;
                    end else if (is_e0) begin
                        err_set = 1'b1;
                    end else begin
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        emit_make  = 1'b1;
                        state_next = IDLE;
                    end
                end
                GOT_F0, GOT_E0F0: begin
                    state_next = IDLE;
                    if (is_e0 || is_f0) begin
                        err_set = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        emit_ext = (state == GOT_E0F0);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Held-key and modifier bookkeeping for the event being emitted this edge.
    always_comb begin
        held_match      = held_valid && (held_code == ps2_data) && (held_ext == emit_ext);
        is_repeat       = emit_make && held_match;
        held_valid_next = held_valid;
        lshift_next     = lshift;
        rshift_next     = rshift;
        caps_next       = caps;
        if (emit) begin
            if (emit_make) begin
                held_valid_next = 1'b1;
            end else if (held_match) begin
                held_valid_next = 1'b0;
            end
            if (!emit_ext) begin
                if (ps2_data == LSHIFT_CODE) begin
                    lshift_next = emit_make;
                end
                if (ps2_data == RSHIFT_CODE) begin
                    rshift_next = emit_make;
                end
                if (ps2_data == CAPS_CODE && emit_make && !is_repeat) begin
                    caps_next = ~caps;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ev_valid    <= 1'b0;
            ev_code     <= 8'h00;
            ev_ext      <= 1'b0;
            ev_make     <= 1'b0;
            ev_repeat   <= 1'b0;
            ev_shift    <= 1'b0;
            ev_caps     <= 1'b0;
            press_count <= 8'h00;
            proto_err   <= 1'b0;
            held_valid  <= 1'b0;
            held_code   <= 8'h00;
            held_ext    <= 1'b0;
            lshift      <= 1'b0;
            rshift      <= 1'b0;
            caps        <= 1'b0;
        end else begin
            if (err_set) begin
                proto_err <= 1'b1;
            end
            if (emit) begin
                ev_valid   <= 1'b1;
                ev_code    <= ps2_data;
                ev_ext     <= emit_ext;
                ev_make    <= emit_make;
                ev_repeat  <= is_repeat;
                ev_shift   <= lshift_next | rshift_next;
                ev_caps    <= caps_next;
                held_valid <= held_valid_next;
                lshift     <= lshift_next;
                rshift     <= rshift_next;
                caps       <= caps_next;
                if (emit_make && !is_repeat) begin
                    held_code   <= ps2_data;
                    held_ext    <= emit_ext;
                    press_count <= press_count + 8'd1;
                end
            end else if (ev_ready) begin
                ev_valid <= 1'b0;
            end
        end
    end

endmodule
